axi_slave_arbiter: RTL
======================

# axi_slave_arbiter

- Connects `AXI_MASTER_PORT` upstream AXI4 masters to one downstream AXI4 slave.
- Upstream side uses packed per-port channel vectors, so each input port slice connects directly to one port slice of an `axi_master_router` `M_AXI_*` bundle.
- Write and read paths arbitrate independently, each round-robin, one outstanding transaction per direction.
- Sits in front of each shared slave in the interconnect.

## Interface
- `AXI_ID_WIDTH`, 1, ID width; passed through unmodified.
- `AXI_DATA_WIDTH`, 32, data width.
- `AXI_ADDR_WIDTH`, 8, address width.
- `AXI_MASTER_PORT`, 2, number of upstream ports N; N ≥ 2.
- `AXI_AWCHAN_WIDTH`/`AXI_ARCHAN_WIDTH`, ID+ADDR+13, packed as {ID, LEN[7:0], SIZE[2:0], BURST[1:0], ADDR}; ADDR in LSBs.
- `AXI_WDCHAN_WIDTH`, DATA+DATA/8+1, packed as {DATA, STRB, LAST}; LAST is bit 0.
- `AXI_WBCHAN_WIDTH`, ID+2, packed as {BRESP, BID}.
- `AXI_RDCHAN_WIDTH`, ID+DATA+3, packed as {RDATA, RRESP, RLAST, RID}; RLAST is bit `AXI_ID_WIDTH`.

Ports:
- `ACLK`  input  1  clock.
- `ARESETN`  input  1  reset, asynchronous, active-low.
- `S_AXI_AWCH_i`/`_VALID_i`/`_READY_o`  in/in/out  AWCHAN*N / N / N  upstream AW, port i at slice i.
- `S_AXI_WCH_i`/`_VALID_i`/`_READY_o`  in/in/out  WDCHAN*N / N / N  upstream W.
- `S_AXI_BCH_o`/`_VALID_o`/`_READY_i`  out/out/in  WBCHAN*N / N / N  upstream B.
- `S_AXI_ARCH_i`/`_VALID_i`/`_READY_o`  in/in/out  ARCHAN*N / N / N  upstream AR.
- `S_AXI_RCH_o`/`_VALID_o`/`_READY_i`  out/out/in  RDCHAN*N / N / N  upstream R.
- `M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID`  output; `M_AXI_AWREADY` input  downstream AW.
- `M_AXI_WDATA/WSTRB/WLAST/WVALID`  output; `M_AXI_WREADY` input  downstream W.
- `M_AXI_BID/BRESP/BVALID`  input; `M_AXI_BREADY` output  downstream B.
- `M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID`  output; `M_AXI_ARREADY` input  downstream AR.
- `M_AXI_RID/RDATA/RRESP/RLAST/RVALID`  input; `M_AXI_RREADY` output  downstream R.

## Operation

**Write FSM:** `W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE`.
- `W_IDLE`: if any `S_AXI_AWCH_VALID_i` bit is set, register `wgrant` (one-hot) and go to `W_ADDR`.
- `W_ADDR`: `M_AXI_AW*` = slice `wgrant`; `AWVALID` = `VALID_i[wgrant]`; `READY_o[wgrant]` = `M_AXI_AWREADY`. On handshake go to `W_DATA`.
- `W_DATA`: W slice `wgrant` forwarded likewise. On a W handshake with WLAST=1 go to `W_RESP`.
- `W_RESP`: `M_AXI_BREADY` = `S_AXI_BCH_READY_i[wgrant]`; `S_AXI_BCH_VALID_o[wgrant]` = `M_AXI_BVALID`. On handshake go to `W_IDLE`.

**Read FSM:** `R_IDLE → R_ADDR → R_DATA → R_IDLE`.
- Same grant and forwarding rules as the write FSM, using `rgrant`.
- `R_DATA` ends on an R handshake with RLAST=1.

**Arbitration:**
- Round-robin per direction. Search starts at last-granted+1, modulo N.
- Reset pointer is N-1, so port 0 wins first.

**Datapaths:**
- All datapaths are combinational muxes, no buffering.
- `S_AXI_BCH_o` and `S_AXI_RCH_o` broadcast the downstream fields to every slice; only the granted `VALID_o` bit can be 1.
- All non-granted `READY_o`/`VALID_o` bits are 0.
- Any channel outside its active state drives `VALID`/`READY` = 0.

**Boundary conditions:**
- Upstream W arriving before its AW stalls (`WREADY`=0) until `W_DATA`.
- Downstream `BVALID`/`RVALID` outside `W_RESP`/`R_DATA` is ignored (`READY`=0).
- Write and read FSMs may grant different or the same ports simultaneously.
- A granted port that drops `VALID` in `W_ADDR`/`R_ADDR` keeps the grant; it is not re-arbitrated.
- Reset mid-burst: FSMs return to IDLE, grants clear, pointers return to N-1; no transaction is completed.

## Timing
- Reset value of every `VALID`/`READY` output is 0; data outputs are don't-care but are driven as muxed slice 0 or downstream values.
- Grant latency: AWVALID seen in `W_IDLE` at cycle 0 → `M_AXI_AWVALID`=1 in cycle 1. Same for AR.
- `W_DATA`→`W_IDLE` takes at least 1 cycle in `W_RESP`. Minimum write turnaround is 4 cycles for single beat; read turnaround is 3 cycles.
- All forwarding within a state is zero-latency combinational; ready→valid paths are combinational through the arbiter.

## Configuration
- `AXI_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest index wins, pointer unused.
  - Undefined (default): round-robin as above.
  - FSMs and timing are identical in both cases.

## Test plan
- Single write: port 1 AW addr 0x40 len 0, one W beat, B OKAY → `M_AXI_AWVALID` in cycle 1, B returned only on port 1, port 0 `BVALID`=0.
- Contention: ports 0 and 1 both assert AWVALID after reset → grants 0 then 1. Without the macro, a third request from 0 goes to 1 first; with `AXI_ARB_FIXED_PRIO_EN`, port 0 always wins.
- Burst read: port 0 ARLEN=3 with `M_AXI_RREADY` throttled 1-of-2 → exactly 4 R beats delivered to port 0, FSM back to `R_IDLE` after the RLAST beat.
- Concurrent: port 0 write and port 1 read issued in the same cycle → both `M_AXI_AWVALID` and `M_AXI_ARVALID` asserted in cycle 1, no interference.
- Early W: port 1 asserts WVALID 5 cycles before AWVALID → `WREADY`=0 until AW handshake, then data passes intact.
- Reset during `W_DATA` with 2 of 4 beats sent → all `VALID`/`READY` outputs 0 immediately; the next request is granted normally from `W_IDLE`.

Source files
------------

// File: rtl/axi_slave_arbiter_if.sv
// axi_slave_arbiter_if: downstream AXI4 bundle between the arbiter and one shared slave
// Parameters: AXI_ID_WIDTH, AXI_DATA_WIDTH, AXI_ADDR_WIDTH.
// Modports: master (arbiter side, drives AW/W/AR and BREADY/RREADY),
//           slave  (shared slave side, drives the READYs and B/R channels).
interface axi_slave_arbiter_if #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8
);
    logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID;
    logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [7:0]                  M_AXI_AWLEN;
    logic [2:0]                  M_AXI_AWSIZE;
    logic [1:0]                  M_AXI_AWBURST;
    logic                        M_AXI_AWVALID;
    logic                        M_AXI_AWREADY;
    logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                        M_AXI_WLAST;
    logic                        M_AXI_WVALID;
    logic                        M_AXI_WREADY;
    logic [AXI_ID_WIDTH-1:0]     M_AXI_BID;
    logic [1:0]                  M_AXI_BRESP;
    logic                        M_AXI_BVALID;
    logic                        M_AXI_BREADY;
    logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID;
    logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [7:0]                  M_AXI_ARLEN;
    logic [2:0]                  M_AXI_ARSIZE;
    logic [1:0]                  M_AXI_ARBURST;
    logic                        M_AXI_ARVALID;
    logic                        M_AXI_ARREADY;
    logic [AXI_ID_WIDTH-1:0]     M_AXI_RID;
    logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]                  M_AXI_RRESP;
    logic                        M_AXI_RLAST;
    logic                        M_AXI_RVALID;
    logic                        M_AXI_RREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_slave_arbiter.sv
// axi_slave_arbiter: N-to-1 AXI4 arbiter placed in front of a shared slave
// Write and read paths each run their own FSM and round-robin grant, one
// outstanding transaction per direction; all forwarding is combinational.
// Ports:
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   S_AXI_{AW,W,AR}CH_*      packed upstream request channels, port i at slice i
//   S_AXI_{B,R}CH_*          packed upstream response channels (broadcast data)
//   m_axi                    downstream AXI4 bundle (axi_slave_arbiter_if.master)
// Build option: define AXI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module axi_slave_arbiter #(
    parameter int AXI_ID_WIDTH     = 1,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int AXI_ADDR_WIDTH   = 8,
    parameter int AXI_MASTER_PORT  = 2,
    parameter int AXI_AWCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
    parameter int AXI_ARCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
    parameter int AXI_WDCHAN_WIDTH = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1,
    parameter int AXI_WBCHAN_WIDTH = AXI_ID_WIDTH + 2,
    parameter int AXI_RDCHAN_WIDTH = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3
) (
    input  logic                                         ACLK,
    input  logic                                         ARESETN,
    input  logic [AXI_AWCHAN_WIDTH*AXI_MASTER_PORT-1:0] S_AXI_AWCH_i,
    input  logic [AXI_MASTER_PORT-1:0]                  S_AXI_AWCH_VALID_i,
    output logic [AXI_MASTER_PORT-1:0]                  S_AXI_AWCH_READY_o,
    input  logic [AXI_WDCHAN_WIDTH*AXI_MASTER_PORT-1:0] S_AXI_WCH_i,
    input  logic [AXI_MASTER_PORT-1:0]                  S_AXI_WCH_VALID_i,
    output logic [AXI_MASTER_PORT-1:0]                  S_AXI_WCH_READY_o,
    output logic [AXI_WBCHAN_WIDTH*AXI_MASTER_PORT-1:0] S_AXI_BCH_o,
    output logic [AXI_MASTER_PORT-1:0]                  S_AXI_BCH_VALID_o,
    input  logic [AXI_MASTER_PORT-1:0]                  S_AXI_BCH_READY_i,
    input  logic [AXI_ARCHAN_WIDTH*AXI_MASTER_PORT-1:0] S_AXI_ARCH_i,
    input  logic [AXI_MASTER_PORT-1:0]                  S_AXI_ARCH_VALID_i,
    output logic [AXI_MASTER_PORT-1:0]                  S_AXI_ARCH_READY_o,
    output logic [AXI_RDCHAN_WIDTH*AXI_MASTER_PORT-1:0] S_AXI_RCH_o,
    output logic [AXI_MASTER_PORT-1:0]                  S_AXI_RCH_VALID_o,
    input  logic [AXI_MASTER_PORT-1:0]                  S_AXI_RCH_READY_i,
    axi_slave_arbiter_if.master                          m_axi
);
    localparam int N   = AXI_MASTER_PORT;
    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int AWC = AXI_AWCHAN_WIDTH;
    localparam int ARC = AXI_ARCHAN_WIDTH;
    localparam int WDC = AXI_WDCHAN_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t       w_st, w_nst;
    r_state_t       r_st, r_nst;
    logic [PW-1:0]  w_idx, r_idx;
    logic [PW-1:0]  w_pick, r_pick;
    logic [PW-1:0]  w_sel, r_sel;
    logic [AWC-1:0] aw_s;
    logic [WDC-1:0] w_s;
    logic [ARC-1:0] ar_s;

    // Returns the winning port index; "last" is returned when nothing requests.
    function automatic logic [PW-1:0] pick(input logic [N-1:0] req, input logic [PW-1:0] last);
        logic [PW-1:0] p;
        p = last;
`ifdef AXI_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--)
            if (req[k]) p = PW'(k);
`else
        // Scan backwards so the port right after "last" is written last and wins.
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) p = PW'((int'(last) + k) % N);
`endif
        return p;
    endfunction

    // w_idx/r_idx hold the active grant and double as the round-robin pointer.
    // Outside a transaction the muxes fall back to slice 0.
    assign w_sel  = (w_st == W_IDLE) ? '0 : w_idx;
    assign r_sel  = (r_st == R_IDLE) ? '0 : r_idx;
    assign aw_s   = S_AXI_AWCH_i[w_sel*AWC +: AWC];
    assign w_s    = S_AXI_WCH_i[w_sel*WDC +: WDC];
    assign ar_s   = S_AXI_ARCH_i[r_sel*ARC +: ARC];
    assign w_pick = pick(S_AXI_AWCH_VALID_i, w_idx);
    assign r_pick = pick(S_AXI_ARCH_VALID_i, r_idx);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_st  <= W_IDLE;
            r_st  <= R_IDLE;
            w_idx <= PW'(N - 1);
            r_idx <= PW'(N - 1);
        end else begin
            w_st <= w_nst;
            r_st <= r_nst;
            if (w_st == W_IDLE) w_idx <= w_pick;
            if (r_st == R_IDLE) r_idx <= r_pick;
        end
    end

    always_comb begin
        w_nst = w_st;
        r_nst = r_st;
        case (w_st)
            W_IDLE:  if (|S_AXI_AWCH_VALID_i) w_nst = W_ADDR;
            W_ADDR:  if (S_AXI_AWCH_VALID_i[w_idx] && m_axi.M_AXI_AWREADY) w_nst = W_DATA;
            W_DATA:  if (S_AXI_WCH_VALID_i[w_idx] && m_axi.M_AXI_WREADY && w_s[0]) w_nst = W_RESP;
            W_RESP:  if (m_axi.M_AXI_BVALID && S_AXI_BCH_READY_i[w_idx]) w_nst = W_IDLE;
            default: w_nst = W_IDLE;
        endcase
        case (r_st)
            R_IDLE:  if (|S_AXI_ARCH_VALID_i) r_nst = R_ADDR;
            R_ADDR:  if (S_AXI_ARCH_VALID_i[r_idx] && m_axi.M_AXI_ARREADY) r_nst = R_DATA;
            R_DATA:  if (m_axi.M_AXI_RVALID && S_AXI_RCH_READY_i[r_idx] && m_axi.M_AXI_RLAST) r_nst = R_IDLE;
            default: r_nst = R_IDLE;
        endcase
    end

    always_comb begin
        {m_axi.M_AXI_AWID, m_axi.M_AXI_AWLEN, m_axi.M_AXI_AWSIZE, m_axi.M_AXI_AWBURST, m_axi.M_AXI_AWADDR} = aw_s;
        {m_axi.M_AXI_WDATA, m_axi.M_AXI_WSTRB, m_axi.M_AXI_WLAST} = w_s;
        {m_axi.M_AXI_ARID, m_axi.M_AXI_ARLEN, m_axi.M_AXI_ARSIZE, m_axi.M_AXI_ARBURST, m_axi.M_AXI_ARADDR} = ar_s;
        m_axi.M_AXI_AWVALID = (w_st == W_ADDR) && S_AXI_AWCH_VALID_i[w_idx];
        m_axi.M_AXI_WVALID  = (w_st == W_DATA) && S_AXI_WCH_VALID_i[w_idx];
        m_axi.M_AXI_BREADY  = (w_st == W_RESP) && S_AXI_BCH_READY_i[w_idx];
        m_axi.M_AXI_ARVALID = (r_st == R_ADDR) && S_AXI_ARCH_VALID_i[r_idx];
        m_axi.M_AXI_RREADY  = (r_st == R_DATA) && S_AXI_RCH_READY_i[r_idx];
        S_AXI_AWCH_READY_o = '0;
        S_AXI_WCH_READY_o  = '0;
        S_AXI_BCH_VALID_o  = '0;
        S_AXI_ARCH_READY_o = '0;
        S_AXI_RCH_VALID_o  = '0;
        S_AXI_AWCH_READY_o[w_idx] = (w_st == W_ADDR) && m_axi.M_AXI_AWREADY;
        S_AXI_WCH_READY_o[w_idx]  = (w_st == W_DATA) && m_axi.M_AXI_WREADY;
        S_AXI_BCH_VALID_o[w_idx]  = (w_st == W_RESP) && m_axi.M_AXI_BVALID;
        S_AXI_ARCH_READY_o[r_idx] = (r_st == R_ADDR) && m_axi.M_AXI_ARREADY;
        S_AXI_RCH_VALID_o[r_idx]  = (r_st == R_DATA) && m_axi.M_AXI_RVALID;
        S_AXI_BCH_o = {N{m_axi.M_AXI_BRESP, m_axi.M_AXI_BID}};
        S_AXI_RCH_o = {N{m_axi.M_AXI_RDATA, m_axi.M_AXI_RRESP, m_axi.M_AXI_RLAST, m_axi.M_AXI_RID}};
    end
endmodule
